// File: rtl/bus_invert_serializer.sv
// rtl/bus_invert_serializer.sv - MSB-first 8-bit serializer with bus-invert decision and running disparity
module bus_invert_serializer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic       inv_en,
  output logic       a,
  output logic       inv_signal,
  output logic       bit_valid,
  output logic       first_bit,
  output logic [4:0] disparity
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        word_q, word_d;
  logic              a_q, a_d;
  logic              inv_q, inv_d;
  logic              valid_q, valid_d;
  logic              first_q, first_d;
  logic signed [4:0] rd_q, rd_d;

  logic [3:0]        ones;
  logic signed [5:0] word_disp;
  logic signed [5:0] rd_ext;
  logic signed [5:0] rd_next;
  logic              invert;
  logic              take;

  assign din_ready  = rst_n && ((state_q == ST_IDLE) || (bit_cnt_q == 3'd0));
  assign take       = din_valid && din_ready;
  assign a          = a_q;
  assign inv_signal = inv_q;
  assign bit_valid  = valid_q;
  assign first_bit  = first_q;
  assign disparity  = rd_q;

  // Word disparity and the invert decision; |rd| stays within 8 because
  // inversion only happens when rd and d share a sign.
  always_comb begin
    ones = 4'd0;
    for (int i = 0; i < 8; i++) begin
      ones = ones + {3'd0, din[i]};
    end
    word_disp = $signed({1'b0, ones, 1'b0}) - 6'sd8;
    rd_ext    = {rd_q[4], rd_q};
    invert    = inv_en && (word_disp != 6'sd0) && (rd_q != 5'sd0) &&
                (word_disp[5] == rd_q[4]);
    rd_next   = invert ? (rd_ext - word_disp) : (rd_ext + word_disp);
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    word_d    = word_q;
    a_d       = a_q;
    inv_d     = inv_q;
    valid_d   = valid_q;
    first_d   = first_q;
    rd_d      = rd_q;
    if (take) begin
      state_d   = ST_SHIFT;
      bit_cnt_d = 3'd7;
      word_d    = din;
      a_d       = din[7];
      first_d   = 1'b1;
      valid_d   = 1'b1;
      inv_d     = invert;
      if (inv_en) begin
        rd_d = rd_next[4:0];
      end
    end else if (state_q == ST_SHIFT) begin
      if (bit_cnt_q != 3'd0) begin
        bit_cnt_d = bit_cnt_q - 3'd1;
        a_d       = word_q[bit_cnt_q - 3'd1];
        first_d   = 1'b0;
      end else begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        first_d = 1'b0;
        inv_d   = 1'b0;
        a_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      word_q    <= 8'd0;
      a_q       <= 1'b0;
      inv_q     <= 1'b0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      rd_q      <= 5'sd0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      word_q    <= word_d;
      a_q       <= a_d;
      inv_q     <= inv_d;
      valid_q   <= valid_d;
      first_q   <= first_d;
      rd_q      <= rd_d;
    end
  end

endmodule

// File: tb/tb_bus_invert_serializer.sv
// tb/tb_bus_invert_serializer.sv - directed-vector bench for bus_invert_serializer
module tb_bus_invert_serializer;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       inv_en;
  logic       a;
  logic       inv_signal;
  logic       bit_valid;
  logic       first_bit;
  logic [4:0] disparity;

  int n_cmp = 0;
  int n_err = 0;

  bus_invert_serializer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .inv_en     (inv_en),
    .a          (a),
    .inv_signal (inv_signal),
    .bit_valid  (bit_valid),
    .first_bit  (first_bit),
    .disparity  (disparity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    din_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    din_valid = 1'b0;
    din       = 8'h00;
    inv_en    = 1'b1;
    step();
    step();
    n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL reset_bit_valid got %b exp 0", bit_valid); end
    n_cmp++; if (a !== 1'b0) begin n_err++; $display("FAIL reset_a got %b exp 0", a); end
    n_cmp++; if (inv_signal !== 1'b0) begin n_err++; $display("FAIL reset_inv got %b exp 0", inv_signal); end
    n_cmp++; if (first_bit !== 1'b0) begin n_err++; $display("FAIL reset_first got %b exp 0", first_bit); end
    n_cmp++; if (disparity !== 5'd0) begin n_err++; $display("FAIL reset_disp got %h exp 0", disparity); end
    n_cmp++; if (din_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_low got %b exp 0", din_ready); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (din_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_reset got %b exp 1", din_ready); end
  endtask

  task automatic test_bus_invert();
    logic [7:0] words [3] = '{8'hFF, 8'hF0, 8'hFE};
    logic [7:0] exp_y [3] = '{8'hFF, 8'hF0, 8'h01};
    logic       exp_inv [3] = '{1'b0, 1'b0, 1'b1};
    logic [4:0] exp_rd [3] = '{5'd8, 5'd8, 5'd2};
    logic [7:0] w;
    logic [7:0] y;
    inv_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      w = words[k];
      y = exp_y[k];
      n_cmp++; if (din_ready !== 1'b1) begin n_err++; $display("FAIL bi_ready_idle w%0d got %b exp 1", k, din_ready); end
      din       = w;
      din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
        n_cmp++; if (bit_valid !== 1'b1) begin n_err++; $display("FAIL bi_valid w%0d b%0d got %b exp 1", k, i, bit_valid); end
        n_cmp++; if (a !== w[7-i]) begin n_err++; $display("FAIL bi_a w%0d b%0d got %b exp %b", k, i, a, w[7-i]); end
        n_cmp++; if (inv_signal !== exp_inv[k]) begin n_err++; $display("FAIL bi_inv w%0d b%0d got %b exp %b", k, i, inv_signal, exp_inv[k]); end
        n_cmp++; if ((a ^ inv_signal) !== y[7-i]) begin n_err++; $display("FAIL bi_y w%0d b%0d got %b exp %b", k, i, a ^ inv_signal, y[7-i]); end
        n_cmp++; if (first_bit !== (i == 0)) begin n_err++; $display("FAIL bi_first w%0d b%0d got %b exp %b", k, i, first_bit, i == 0); end
        n_cmp++; if (disparity !== exp_rd[k]) begin n_err++; $display("FAIL bi_disp w%0d b%0d got %h exp %h", k, i, disparity, exp_rd[k]); end
        n_cmp++; if (din_ready !== (i == 7)) begin n_err++; $display("FAIL bi_ready w%0d b%0d got %b exp %b", k, i, din_ready, i == 7); end
        step();
      end
      n_cmp++; if (bit_valid !== 1'b0 || a !== 1'b0 || inv_signal !== 1'b0) begin
        n_err++; $display("FAIL bi_idle w%0d got v%b a%b i%b exp 000", k, bit_valid, a, inv_signal);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_a = 16'b1010_0101_0011_1100;
    apply_reset();
    inv_en    = 1'b1;
    din       = 8'hA5;
    din_valid = 1'b1;
    step();
    din = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (bit_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid c%0d got %b exp 1", i, bit_valid); end
      n_cmp++; if (a !== exp_a[15-i]) begin n_err++; $display("FAIL b2b_a c%0d got %b exp %b", i, a, exp_a[15-i]); end
      n_cmp++; if (first_bit !== (i == 0 || i == 8)) begin n_err++; $display("FAIL b2b_first c%0d got %b exp %b", i, first_bit, i == 0 || i == 8); end
      n_cmp++; if (inv_signal !== 1'b0 || disparity !== 5'd0) begin n_err++; $display("FAIL b2b_inv_disp c%0d got %b/%h exp 0/0", i, inv_signal, disparity); end
      if (i == 8) din_valid = 1'b0;
      step();
    end
    n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end got %b exp 0", bit_valid); end
  endtask

  task automatic test_inv_disabled();
    apply_reset();
    inv_en    = 1'b0;
    din       = 8'hFF;
    din_valid = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (bit_valid !== 1'b1 || a !== 1'b1) begin n_err++; $display("FAIL dis_bit c%0d got v%b a%b exp 11", i, bit_valid, a); end
      n_cmp++; if (inv_signal !== 1'b0) begin n_err++; $display("FAIL dis_inv c%0d got %b exp 0", i, inv_signal); end
      n_cmp++; if (disparity !== 5'd0) begin n_err++; $display("FAIL dis_disp c%0d got %h exp 0", i, disparity); end
      if (i == 8) din_valid = 1'b0;
      step();
    end
    n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL dis_end got %b exp 0", bit_valid); end
  endtask

  task automatic test_inv_midword();
    apply_reset();
    inv_en    = 1'b1;
    din       = 8'hFF;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    din       = 8'hF8;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) inv_en = 1'b0;
      n_cmp++; if (inv_signal !== 1'b1) begin n_err++; $display("FAIL mid_inv_held b%0d got %b exp 1", i, inv_signal); end
      n_cmp++; if (disparity !== 5'd6) begin n_err++; $display("FAIL mid_disp b%0d got %h exp 6", i, disparity); end
      step();
    end
    din       = 8'hFF;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    n_cmp++; if (inv_signal !== 1'b0) begin n_err++; $display("FAIL mid_next_inv got %b exp 0", inv_signal); end
    n_cmp++; if (disparity !== 5'd6) begin n_err++; $display("FAIL mid_next_disp got %h exp 6", disparity); end
    for (int i = 0; i < 8; i++) step();
    inv_en = 1'b1;
  endtask

  task automatic test_reset_midword();
    apply_reset();
    inv_en    = 1'b1;
    din       = 8'hFF;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_cmp++; if (disparity !== 5'd8 || bit_valid !== 1'b1) begin n_err++; $display("FAIL rm_pre got d%h v%b exp d08 v1", disparity, bit_valid); end
    rst_n = 1'b0;
    step();
    n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid got %b exp 0", bit_valid); end
    n_cmp++; if (a !== 1'b0) begin n_err++; $display("FAIL rm_a got %b exp 0", a); end
    n_cmp++; if (inv_signal !== 1'b0) begin n_err++; $display("FAIL rm_inv got %b exp 0", inv_signal); end
    n_cmp++; if (disparity !== 5'd0) begin n_err++; $display("FAIL rm_disp got %h exp 0", disparity); end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL rm_no_more c%0d got %b exp 0", i, bit_valid); end
    end
  endtask

  task automatic test_din_change();
    logic [7:0] w = 8'h96;
    apply_reset();
    inv_en    = 1'b1;
    din       = w;
    din_valid = 1'b1;
    step();
    din = 8'h69;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (a !== w[7-i] || bit_valid !== 1'b1) begin n_err++; $display("FAIL chg_a b%0d got a%b v%b exp a%b v1", i, a, bit_valid, w[7-i]); end
      n_cmp++; if (first_bit !== (i == 0)) begin n_err++; $display("FAIL chg_first b%0d got %b exp %b", i, first_bit, i == 0); end
      if (i == 6) din_valid = 1'b0;
      step();
    end
    n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL chg_extra got %b exp 0", bit_valid); end
    n_cmp++; if (disparity !== 5'd0) begin n_err++; $display("FAIL chg_disp got %h exp 0", disparity); end
  endtask

  initial begin
    rst_n     = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;
    inv_en    = 1'b1;
    test_reset();
    test_bus_invert();
    test_back_to_back();
    test_inv_disabled();
    test_inv_midword();
    test_reset_midword();
    test_din_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
